cla_subtractor_pipe: RTL and testbench
======================================

# cla_subtractor_pipe

Pipelined unsigned subtractor with borrow lookahead, handshaked input and output stages. It is the inverse-operation companion to the team's registered 4-bit carry-lookahead adder. It accepts operand pairs A and B plus a borrow-in, and returns D = A − B − bin with a borrow-out and a zero flag, two cycles after acceptance. Valid/ready flow control with full backpressure lets it sit directly in the datapath next to the adder and feed downstream consumers at one result per cycle.

## Interface
- WIDTH, 4, operand/result width; multiple of 4, range 4..16; lookahead is done in 4-bit groups, rippled between groups
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand pair presented
- in_ready  out  1  stage 1 can accept this cycle
- A  in  WIDTH  minuend
- B  in  WIDTH  subtrahend
- bin  in  1  borrow-in (chaining)
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts result
- D  out  WIDTH  difference
- bout  out  1  borrow-out; 1 iff A < B + bin
- zero  out  1  1 iff D == 0

## Operation
- Stage 1 (S1): registers A, B, bin on accept (in_valid & in_ready); s1_valid flag.
- Stage 2 (S2): computes the difference from the S1 registers; registers D, bout, zero; s2_valid drives out_valid.
- Per bit: generate g = ~a & b, propagate p = ~(a ^ b), d = a ^ b ^ borrow_i.
- Group borrow: c[i+1] = g[i] | p[i] & c[i], expanded in parallel within each 4-bit group; group borrow-out feeds the next group's c[0]; c[0] of group 0 = bin.
- Arithmetic: D = (A − B − bin) mod 2^WIDTH; bout = c[WIDTH]; zero evaluated on final D (after saturation if enabled).
- Flow: s2_adv = ~s2_valid | out_ready; in_ready = ~s1_valid | s2_adv (combinational, no bubble); S1 moves to S2 when s1_valid & s2_adv.
- Stall: while out_valid & ~out_ready, D/bout/zero/out_valid hold stable; S1 holds if also full; in_ready = 0 only when both stages full and out_ready = 0.
- Simultaneous accept, advance and drain in one cycle are legal; throughput is 1 per cycle.
- No data is dropped or duplicated; results leave in acceptance order.

## Timing
- Reset (rst = 1 at an edge): s1_valid = 0, s2_valid = 0, all data registers = 0. Next cycle: out_valid = 0, D = 0, bout = 0, zero = 0, in_ready = 1.
- Reset mid-operation flushes both stages. Inputs presented during the rst cycle are not accepted.
- Latency: operands accepted at edge N give out_valid = 1 and the result after edge N+1, with no stall.
- in_ready depends on out_ready combinationally. out_valid, D, bout and zero come only from registers.
- Inputs are sampled only at the accepting edge. A/B changes while in_valid = 0 have no effect.

## Configuration
- SUB_SATURATE_EN defined: when bout = 1, D is forced to 0, zero = 1, and bout is still reported as 1 (clamp at floor).
- SUB_SATURATE_EN undefined: D is the modular result and zero reflects it. No clamp logic is present.

## Test plan
- WIDTH = 4, A = 9, B = 3, bin = 0, out_ready = 1 -> two cycles later D = 6, bout = 0, zero = 0.
- A = 3, B = 9, bin = 0 -> D = 10, bout = 1, zero = 0; with SUB_SATURATE_EN: D = 0, bout = 1, zero = 1.
- A = 5, B = 4, bin = 1 -> D = 0, bout = 0, zero = 1. A = 0, B = 15, bin = 1 -> D = 0, bout = 1 (modular).
- Exhaustive stream of all 512 (A, B, bin) triples, one per cycle, out_ready = 1 -> 512 results in order with no gaps, each matching the reference model.
- Backpressure: stream 4 operand pairs, hold out_ready = 0 for 3 cycles after the first result -> in_ready drops once both stages are full, and D holds. After out_ready returns, all 4 results arrive in order with none lost.
- Reset mid-flight: two transactions in flight, assert rst for 1 cycle -> next cycle out_valid = 0, D = 0, in_ready = 1. Neither transaction is ever output, and a new pair is accepted immediately after.

Source files
------------

// File: rtl/cla_subtractor_pipe_if.sv
// Handshake bus for cla_subtractor_pipe: operand stream in, difference stream out.
// master = producer/consumer side (bench), slave = the subtractor.
interface cla_subtractor_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, A, B, bin, out_ready,
    input  in_ready, out_valid, D, bout, zero
  );

  modport slave (
    input  in_valid, A, B, bin, out_ready,
    output in_ready, out_valid, D, bout, zero
  );
endinterface

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined unsigned subtractor, D = A - B - bin, with borrow lookahead
// inside 4-bit groups and group borrows rippled between groups.
// Optional macro SUB_SATURATE_EN clamps underflowing results to zero.

// One 4-bit borrow-lookahead group; all internal borrows are flat sum-of-products.
module cla_sub_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] d,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;

  assign g = ~a & b;
  assign p = ~(a ^ b);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign d    = a ^ b ^ c[3:0];
  assign cout = c[4];
endmodule

module cla_subtractor_pipe #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cla_subtractor_pipe_if.slave  bus
);
  localparam int NG = WIDTH / 4;

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic             s1_bin;
  logic [WIDTH-1:0] s2_d;
  logic             s2_bout, s2_zero;

  logic             s2_adv, in_fire;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] diff, d_fin;

  // Output stage can take new data when empty or being drained this cycle.
  assign s2_adv   = ~s2_valid | bus.out_ready;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign bus.in_ready = ~s1_valid | s2_adv;

  // Group chain: group borrow-out feeds the next group's borrow-in.
  assign gc[0] = s1_bin;
  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_sub_group u_grp (
      .a    (s1_a[gi*4 +: 4]),
      .b    (s1_b[gi*4 +: 4]),
      .cin  (gc[gi]),
      .d    (diff[gi*4 +: 4]),
      .cout (gc[gi+1])
    );
  end

  // Final difference, clamped at zero on underflow when saturation is built in.
  always_comb begin
`ifdef SUB_SATURATE_EN
    d_fin = gc[NG] ? '0 : diff;
`else
    d_fin = diff;
`endif
  end

  // Stage 1: capture operands on accept; empties when it hands off to stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_bin   <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_a     <= bus.A;
        s1_b     <= bus.B;
        s1_bin   <= bus.bin;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: register result when allowed to advance; holds stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_d     <= '0;
      s2_bout  <= 1'b0;
      s2_zero  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_d    <= d_fin;
        s2_bout <= gc[NG];
        s2_zero <= (d_fin == '0);
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.D         = s2_d;
  assign bus.bout      = s2_bout;
  assign bus.zero      = s2_zero;
endmodule

// File: tb/tb_cla_subtractor_pipe.sv
// Self-checking bench for cla_subtractor_pipe (WIDTH = 4); honours SUB_SATURATE_EN.
module tb_cla_subtractor_pipe;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  cla_subtractor_pipe_if #(.WIDTH(W)) bus ();

  cla_subtractor_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed results {D, bout, zero} with the cycle they were consumed.
  logic [W+1:0] obs_q[$];
  int           ocyc_q[$];

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      obs_q.push_back({bus.D, bus.bout, bus.zero});
      ocyc_q.push_back(cyc);
    end
  end

  // Reference: plain integer arithmetic, wrapped into WIDTH bits.
  function automatic logic [W+1:0] model(input int a, input int b, input int bi);
    int full;
    int m;
    logic bo;
    logic [W-1:0] dv;
    full = a - b - bi;
    bo = (full < 0);
    m = bo ? full + (1 << W) : full;
    dv = m[W-1:0];
`ifdef SUB_SATURATE_EN
    if (bo) dv = '0;
`endif
    return {dv, bo, (dv == '0)};
  endfunction

  // Present one operand pair and hold it until accepted (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                      output bit ok, output int tries);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.bin = bi;
    ok = 1'b0;
    tries = 0;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk); #1;
      tries++;
    end
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 60 && obs_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.D !== '0) begin errors++; $display("FAIL reset_D got %0d want 0", bus.D); end
    checks++; if (bus.bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bus.bout); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", bus.zero); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  // Spec vectors with fixed expectations plus two-cycle latency.
  task automatic test_directed();
    logic [W-1:0] av[4] = '{4'd9, 4'd3, 4'd5, 4'd0};
    logic [W-1:0] bv[4] = '{4'd3, 4'd9, 4'd4, 4'd15};
    logic         cv[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef SUB_SATURATE_EN
    logic [W+1:0] ev[4] = '{{4'd6, 1'b0, 1'b0}, {4'd0, 1'b1, 1'b1}, {4'd0, 1'b0, 1'b1}, {4'd0, 1'b1, 1'b1}};
`else
    logic [W+1:0] ev[4] = '{{4'd6, 1'b0, 1'b0}, {4'd10, 1'b1, 1'b0}, {4'd0, 1'b0, 1'b1}, {4'd0, 1'b1, 1'b1}};
`endif
    bit ok;
    int t;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      obs_q.delete(); ocyc_q.delete();
      send(av[i], bv[i], cv[i], ok, t);
      bus.in_valid = 1'b0;
      checks++; if (!ok || t != 1) begin errors++; $display("FAIL dir%0d_accept got tries=%0d want 1", i, t); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, bus.out_valid); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got %b want 1", i, bus.out_valid); end
      checks++; if ({bus.D, bus.bout, bus.zero} !== ev[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, {bus.D, bus.bout, bus.zero}, ev[i]); end
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL dir%0d_count got %0d want 1", i, obs_q.size()); end
    end
  endtask

  task automatic test_exhaustive();
    bit ok;
    int t;
    int slow = 0;
    obs_q.delete(); ocyc_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 512; i++) begin
      send(i[3:0], i[7:4], i[8], ok, t);
      if (!ok || t != 1) slow++;
    end
    bus.in_valid = 1'b0;
    wait_obs(512);
    checks++; if (slow != 0) begin errors++; $display("FAIL exh_stall got %0d stalled accepts want 0", slow); end
    checks++; if (obs_q.size() != 512) begin errors++; $display("FAIL exh_count got %0d want 512", obs_q.size()); end
    for (int i = 0; i < 512 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== model(i[3:0], i[7:4], i[8])) begin
        errors++; $display("FAIL exh_result[%0d] got %h want %h", i, obs_q[i], model(i[3:0], i[7:4], i[8]));
      end
      if (i > 0) begin
        checks++;
        if (ocyc_q[i] != ocyc_q[i-1] + 1) begin errors++; $display("FAIL exh_gap[%0d] got cycle %0d want %0d", i, ocyc_q[i], ocyc_q[i-1] + 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] av[4], bv[4];
    logic         cv[4];
    logic [W+1:0] held;
    bit ok;
    bit seen;
    int t;
    for (int i = 0; i < 4; i++) begin
      av[i] = W'($urandom); bv[i] = W'($urandom); cv[i] = 1'($urandom);
    end
    obs_q.delete(); ocyc_q.delete();
    bus.out_ready = 1'b1;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          send(av[i], bv[i], cv[i], ok, t);
          checks++; if (!ok) begin errors++; $display("FAIL bp_send%0d got timeout want accept", i); end
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20 && !seen; k++) begin
          @(posedge clk); #1;
          seen = bus.out_valid;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_first_result got none want out_valid"); end
        bus.out_ready = 1'b0;
        held = {bus.D, bus.bout, bus.zero};
        checks++; if (held !== model(av[0], bv[0], cv[0])) begin errors++; $display("FAIL bp_first got %h want %h", held, model(av[0], bv[0], cv[0])); end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, bus.in_ready); end
          checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", k, bus.out_valid); end
          checks++; if ({bus.D, bus.bout, bus.zero} !== held) begin errors++; $display("FAIL bp_hold[%0d] got %h want %h", k, {bus.D, bus.bout, bus.zero}, held); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_obs(4);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL bp_count got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== model(av[i], bv[i], cv[i])) begin errors++; $display("FAIL bp_result[%0d] got %h want %h", i, obs_q[i], model(av[i], bv[i], cv[i])); end
    end
  endtask

  // Random stream with random consumer stalls; order and values against the model.
  task automatic test_back_to_back();
    localparam int N = 40;
    logic [W-1:0] av[N], bv[N];
    logic         cv[N];
    bit ok;
    bit done;
    int t;
    int lost = 0;
    for (int i = 0; i < N; i++) begin
      av[i] = W'($urandom); bv[i] = W'($urandom); cv[i] = 1'($urandom);
    end
    obs_q.delete(); ocyc_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          send(av[i], bv[i], cv[i], ok, t);
          if (!ok) lost++;
        end
        bus.in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_obs(N);
    checks++; if (lost != 0) begin errors++; $display("FAIL b2b_send got %0d timeouts want 0", lost); end
    checks++; if (obs_q.size() != N) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), N); end
    for (int i = 0; i < N && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== model(av[i], bv[i], cv[i])) begin errors++; $display("FAIL b2b_result[%0d] got %h want %h", i, obs_q[i], model(av[i], bv[i], cv[i])); end
    end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    int t;
    obs_q.delete(); ocyc_q.delete();
    bus.out_ready = 1'b0;
    send(4'd12, 4'd5, 1'b0, ok, t);
    send(4'd7, 4'd7, 1'b0, ok, t);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.A = 4'd15; bus.B = 4'd1; bus.bin = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmf_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.D !== '0) begin errors++; $display("FAIL rmf_D got %0d want 0", bus.D); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmf_in_ready got %b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    send(4'd8, 4'd2, 1'b1, ok, t);
    bus.in_valid = 1'b0;
    checks++; if (!ok || t != 1) begin errors++; $display("FAIL rmf_accept got tries=%0d want 1", t); end
    wait_obs(1);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL rmf_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0] !== model(8, 2, 1)) begin errors++; $display("FAIL rmf_result got %h want %h", obs_q[0], model(8, 2, 1)); end
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
